// File: rtl/dmem_responder.sv
// Data-memory responder: one word access at a time, fixed latency,
// single-cycle ready pulse with err flag for illegal accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic            bad_q, bad_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            enter_done;
  logic            req;
  logic            in_bad;
  logic            unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  assign req         = mem_rd | mem_wr;
  assign in_bad      = (addr[1:0] != 2'b00) | (mem_rd & mem_wr);
  assign unused_addr = &{1'b0, addr[31:AW+2]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    bad_d      = bad_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    enter_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = addr[AW+1:2];
          wdata_d = wdata;
          wr_d    = mem_wr;
          bad_d   = in_bad;
          if (LATENCY == 1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // With LATENCY==1 the _d values are the freshly captured request.
    if (enter_done) begin
      err_d = bad_d;
      if (bad_d) begin
        rdata_d = '0;
      end else if (!wr_d) begin
        rdata_d = mem[idx_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == DONE && wr_q && !bad_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance,
// plus LATENCY=1 and LATENCY=4 instances for latency/throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        m_rd = 0, m_wr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [31:0] m_rdata;
  logic        m_ready, m_busy, m_err;

  logic        r1_rd = 0, r1_wr = 0;
  logic [31:0] r1_addr = 0, r1_wdata = 0;
  logic [31:0] r1_rdata;
  logic        r1_ready, r1_busy, r1_err;

  logic        r4_rd = 0, r4_wr = 0;
  logic [31:0] r4_addr = 0, r4_wdata = 0;
  logic [31:0] r4_rdata;
  logic        r4_ready, r4_busy, r4_err;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .mem_rd(m_rd), .mem_wr(m_wr),
    .addr(m_addr), .wdata(m_wdata), .rdata(m_rdata),
    .ready(m_ready), .busy(m_busy), .err(m_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_rd(r1_rd), .mem_wr(r1_wr),
    .addr(r1_addr), .wdata(r1_wdata), .rdata(r1_rdata),
    .ready(r1_ready), .busy(r1_busy), .err(r1_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .mem_rd(r4_rd), .mem_wr(r4_wr),
    .addr(r4_addr), .wdata(r4_wdata), .rdata(r4_rdata),
    .ready(r4_ready), .busy(r4_busy), .err(r4_err)
  );

  // lat = negedges after the request is raised until ready is seen
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int bcnt,
                        output logic [31:0] rd_o, output logic e_o,
                        output logic rdy2);
    @(negedge clk);
    m_rd = rd; m_wr = wr; m_addr = a; m_wdata = d;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (m_busy) bcnt++;
    end while (!m_ready && lat < 20);
    rd_o = m_rdata; e_o = m_err;
    m_rd = 0; m_wr = 0;
    @(negedge clk);
    rdy2 = m_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_ready, m_busy, m_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000", {m_ready, m_busy, m_err});
    end
    checks++;
    if (m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=0", m_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int lat, bc; logic [31:0] rd; logic e, r2;
    access(0, 1, 32'h10, 32'hDEADBEEF, lat, bc, rd, e, r2);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL wr_latency got=%0d exp=2", lat);
    end
    checks++;
    if (bc !== 2) begin
      errors++; $display("FAIL wr_busy_cycles got=%0d exp=2", bc);
    end
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL wr_err got=%b exp=0", e);
    end
    checks++;
    if (r2 !== 1'b0) begin
      errors++; $display("FAIL wr_ready_pulse got=%b exp=0", r2);
    end
    access(1, 0, 32'h10, 32'h0, lat, bc, rd, e, r2);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL rd_latency got=%0d exp=2", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd);
    end
    checks++;
    if (e !== 1'b0 || bc !== 2) begin
      errors++; $display("FAIL rd_err_busy got=%b/%0d exp=0/2", e, bc);
    end
  endtask

  task automatic test_wrap;
    int lat, bc; logic [31:0] rd; logic e, r2;
    access(0, 1, 32'h400, 32'h1234, lat, bc, rd, e, r2);
    access(1, 0, 32'h000, 32'h0, lat, bc, rd, e, r2);
    checks++;
    if (rd !== 32'h1234) begin
      errors++; $display("FAIL wrap_data got=%h exp=1234", rd);
    end
  endtask

  task automatic test_misaligned;
    int lat, bc; logic [31:0] rd; logic e, r2;
    access(0, 1, 32'h13, 32'h0BAD0BAD, lat, bc, rd, e, r2);
    checks++;
    if (lat !== 2 || e !== 1'b1) begin
      errors++; $display("FAIL mis_err got=%0d/%b exp=2/1", lat, e);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL mis_rdata got=%h exp=0", rd);
    end
    access(1, 0, 32'h10, 32'h0, lat, bc, rd, e, r2);
    checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL mis_nowrite got=%h/%b exp=deadbeef/0", rd, e);
    end
  endtask

  task automatic test_dual;
    int lat, bc; logic [31:0] rd; logic e, r2;
    access(1, 1, 32'h10, 32'h77777777, lat, bc, rd, e, r2);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL dual_err got=%b/%h exp=1/0", e, rd);
    end
    access(1, 0, 32'h10, 32'h0, lat, bc, rd, e, r2);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL dual_nowrite got=%h exp=deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, bc; logic [31:0] rd; logic e, r2;
    access(0, 1, 32'h20, 32'h11111111, lat, bc, rd, e, r2);
    access(1, 0, 32'h20, 32'h0, lat, bc, rd, e, r2);
    @(negedge clk);
    m_wr = 1; m_addr = 32'h20; m_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy got=%b exp=1", m_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_ready, m_busy, m_err} !== 3'b000 || m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outs got=%b/%h exp=000/0",
               {m_ready, m_busy, m_err}, m_rdata);
    end
    @(negedge clk);
    rst = 1'b0; m_wr = 0;
    access(1, 0, 32'h20, 32'h0, lat, bc, rd, e, r2);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++; $display("FAIL rstmid_data got=%h exp=11111111", rd);
    end
  endtask

  task automatic test_read_hold;
    int lat, bc; logic [31:0] rd; logic e, r2;
    access(0, 1, 32'h30, 32'h55, lat, bc, rd, e, r2);
    access(1, 0, 32'h30, 32'h0, lat, bc, rd, e, r2);
    checks++;
    if (rd !== 32'h55) begin
      errors++; $display("FAIL hold_read got=%h exp=55", rd);
    end
    access(0, 1, 32'h34, 32'h99, lat, bc, rd, e, r2);
    checks++;
    if (rd !== 32'h55 || m_rdata !== 32'h55) begin
      errors++; $display("FAIL hold_after_wr got=%h/%h exp=55", rd, m_rdata);
    end
  endtask

  task automatic test_lat1;
    int cnt, first; logic b3; logic [31:0] d;
    cnt = 0; first = 0; b3 = 1'bx; d = 32'hx;
    @(negedge clk);
    r1_wr = 1; r1_addr = 32'h8; r1_wdata = 32'h77;
    @(negedge clk);
    checks++;
    if (r1_ready !== 1'b1) begin
      errors++; $display("FAIL l1_wr_ready got=%b exp=1", r1_ready);
    end
    r1_wr = 0; r1_rd = 1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (r1_ready) begin
        cnt++;
        if (first == 0) begin
          first = i; d = r1_rdata;
        end
      end
      if (i == 3) b3 = r1_busy;
    end
    r1_rd = 0;
    checks++;
    if (first !== 2 || cnt !== 4) begin
      errors++; $display("FAIL l1_held got=%0d/%0d exp=2/4", first, cnt);
    end
    checks++;
    if (b3 !== 1'b0) begin
      errors++; $display("FAIL l1_idle_gap got=%b exp=0", b3);
    end
    checks++;
    if (d !== 32'h77) begin
      errors++; $display("FAIL l1_rdata got=%h exp=77", d);
    end
  endtask

  task automatic test_lat4;
    int cnt, first; logic b5;
    cnt = 0; first = 0; b5 = 1'bx;
    @(negedge clk);
    r4_wr = 1; r4_addr = 32'h4; r4_wdata = 32'h4444;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (r4_ready) begin
        cnt++;
        if (first == 0) first = i;
      end
      if (i == 5) b5 = r4_busy;
    end
    r4_wr = 0;
    checks++;
    if (first !== 4 || cnt !== 3) begin
      errors++; $display("FAIL l4_held got=%0d/%0d exp=4/3", first, cnt);
    end
    checks++;
    if (b5 !== 1'b0 || r4_err !== 1'b0) begin
      errors++; $display("FAIL l4_idle_gap got=%b/%b exp=0/0", b5, r4_err);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_wrap;
    test_misaligned;
    test_dual;
    test_reset_mid_write;
    test_read_hold;
    test_lat1;
    test_lat4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
